// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: two-port arbiter serialising 8/16-bit accesses onto a byte-wide memory.
// Ports: clk, rst_n (async active-low); per requester a/b: req, we, size, addr, wdata in,
// ack, rdata out; memory side: mem_en, mem_we, mem_addr, mem_wdata out, mem_rdata in
// (valid one cycle after a read strobe); busy out (high outside IDLE).
// Define MEM_ARB_FIXED_PRIO_EN to make port a win every tie instead of round-robin.
module mem_access_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [1:0]        size_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [15:0]       wdata_a,
    output logic              ack_a,
    output logic [15:0]       rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [1:0]        size_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [15:0]       wdata_b,
    output logic              ack_b,
    output logic [15:0]       rdata_b,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;
    state_t state;
    logic pick_b;
    logic sel;
    logic lat_we;
    logic [1:0] lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [7:0] lat_whi;
    logic [7:0] lo_byte;
    logic [15:0] rd;
    logic g_we;
    logic [1:0] g_size;
    logic [ADDR_W-1:0] g_addr;
    logic [15:0] g_wdata;
`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick_b = !req_a;
`else
    logic last_b;
    // On a tie, b only wins when a was the most recent grant.
    assign pick_b = req_b && (!req_a || !last_b);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_b <= 1'b1;
        else if (state == IDLE && (req_a || req_b)) last_b <= pick_b;
`endif
    assign g_we    = pick_b ? we_b    : we_a;
    assign g_size  = pick_b ? size_b  : size_a;
    assign g_addr  = pick_b ? addr_b  : addr_a;
    assign g_wdata = pick_b ? wdata_b : wdata_a;
    // In FIN mem_rdata carries the last strobed byte: high byte of a word, or the lone byte.
    assign rd = lat_size == 2'b00 ? {mem_rdata, lo_byte} :
                lat_size == 2'b10 ? {{8{mem_rdata[7]}}, mem_rdata} : {8'h00, mem_rdata};
    assign rdata_a = (ack_a && !lat_we) ? rd : 16'h0000;
    assign rdata_b = (ack_b && !lat_we) ? rd : 16'h0000;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_whi   <= 8'h00;
            lo_byte   <= 8'h00;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_a || req_b) begin
                    state     <= LO;
                    sel       <= pick_b;
                    lat_we    <= g_we;
                    lat_size  <= g_size;
                    lat_addr  <= g_addr;
                    lat_whi   <= g_wdata[15:8];
                    mem_en    <= 1'b1;
                    mem_we    <= g_we;
                    mem_addr  <= g_addr;
                    mem_wdata <= g_wdata[7:0];
                    busy      <= 1'b1;
                end
                LO: if (lat_size == 2'b00) begin
                    state     <= HI;
                    mem_addr  <= lat_addr + ADDR_W'(1);
                    mem_wdata <= lat_whi;
                end else begin
                    state     <= FIN;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= 8'h00;
                    ack_a     <= !sel;
                    ack_b     <= sel;
                end
                HI: begin
                    state     <= FIN;
                    lo_byte   <= lat_we ? lo_byte : mem_rdata;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= 8'h00;
                    ack_a     <= !sel;
                    ack_b     <= sel;
                end
                default: begin
                    state <= IDLE;
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: self-checking bench for mem_access_arbiter with a byte memory model.
`timescale 1ns/1ps
module tb_mem_access_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 0, we_a = 0, req_b = 0, we_b = 0;
    logic [1:0] size_a = 0, size_b = 0;
    logic [15:0] addr_a = 0, addr_b = 0, wdata_a = 0, wdata_b = 0;
    logic ack_a, ack_b, mem_en, mem_we, busy;
    logic [15:0] rdata_a, rdata_b, mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] mem [0:65535];
    int checks = 0, fails = 0, cyc = 0;

    typedef struct {logic port; logic [15:0] rd; int cyc;} exp_t;
    typedef struct {logic we; logic [15:0] addr; logic [7:0] wd;} stb_t;
    typedef struct {logic port; logic we; logic [1:0] size; logic [15:0] addr; logic [15:0] wdata; logic [15:0] rd;} vec_t;
    exp_t sb[$];
    stb_t stb[$];
    vec_t vecs[8];

    mem_access_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .size_a(size_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .size_b(size_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory: write on strobe, read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            chk("ack_exclusive", 32'(ack_a & ack_b), 0);
            if (!ack_a) chk("rdata_a_quiet", 32'(rdata_a), 0);
            if (!ack_b) chk("rdata_b_quiet", 32'(rdata_b), 0);
            if (!mem_en) chk("mem_quiet", {mem_we, mem_addr, mem_wdata}, 0);
            else stb.push_back('{mem_we, mem_addr, mem_wdata});
            if (ack_a || ack_b) begin
                if (sb.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_ack: got ack_a=%b ack_b=%b expected none", ack_a, ack_b);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 32'(ack_b), 32'(e.port));
                    chk("ack_rdata", 32'(ack_b ? rdata_b : rdata_a), 32'(e.rd));
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic p, input logic r, input logic w, input logic [1:0] s,
                         input logic [15:0] a, input logic [15:0] d);
        if (p) begin req_b = r; we_b = w; size_b = s; addr_b = a; wdata_b = d; end
        else begin req_a = r; we_a = w; size_a = s; addr_a = a; wdata_a = d; end
    endtask

    task automatic wait_idle();
        @(posedge clk); #1;
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
        chk("idle_reached", 32'(busy), 0);
    endtask

    task automatic do_access(input vec_t v);
        logic [15:0] a1;
        int n;
        n = (v.size == 2'b00) ? 2 : 1;
        a1 = v.addr + 16'd1;
        wait_idle();
        stb.delete();
        drive(v.port, 1'b1, v.we, v.size, v.addr, v.wdata);
        sb.push_back('{v.port, v.rd, cyc + n + 1});
        @(posedge clk); #1;
        drive(v.port, 1'b0, ~v.we, ~v.size, ~v.addr, ~v.wdata);
        for (int i = 0; i < n + 1; i++) @(posedge clk);
        #1;
        chk("ack_seen", sb.size(), 0);
        sb.delete();
        chk("strobe_count", stb.size(), n);
        if (stb.size() >= 1) chk("strobe_lo", {stb[0].we, stb[0].addr, stb[0].wd}, {v.we, v.addr, v.wdata[7:0]});
        if (n == 2 && stb.size() >= 2) chk("strobe_hi", {stb[1].we, stb[1].addr, stb[1].wd}, {v.we, a1, v.wdata[15:8]});
    endtask

    initial begin
        int na, nb, c0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
        mem[16'h0003] = 8'h85; mem[16'h0004] = 8'h66;
        vecs[0] = '{1'b0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'h1234};
        vecs[1] = '{1'b0, 1'b0, 2'b01, 16'h0003, 16'h0000, 16'h0085};
        vecs[2] = '{1'b1, 1'b0, 2'b10, 16'h0003, 16'h0000, 16'hFF85};
        vecs[3] = '{1'b1, 1'b0, 2'b11, 16'h0003, 16'h0000, 16'h0085};
        vecs[4] = '{1'b1, 1'b1, 2'b00, 16'hFFFF, 16'hBEEF, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 2'b01, 16'h0100, 16'h5A77, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'hBEEF};
        vecs[7] = '{1'b1, 1'b0, 2'b10, 16'h0011, 16'h0000, 16'h0012};
        #1;
        chk("reset_outputs", {ack_a, ack_b, rdata_a, rdata_b, mem_en, mem_we, busy}, 0);
        chk("reset_mem_bus", {mem_addr, mem_wdata}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Both ports request continuously for four word reads each, first tie right after reset.
        wait_idle();
        stb.delete();
        c0 = cyc;
        drive(1'b0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 16'h0003, 16'h0000);
        for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            sb.push_back('{(k >= 4), (k >= 4) ? 16'h6685 : 16'h1234, c0 + 3 + 4 * k});
`else
            sb.push_back('{k[0], k[0] ? 16'h6685 : 16'h1234, c0 + 3 + 4 * k});
`endif
        end
        na = 0; nb = 0;
        for (int i = 0; i < 60 && (na < 4 || nb < 4); i++) begin
            @(negedge clk);
            if (ack_a) na++;
            if (ack_b) nb++;
            @(posedge clk); #1;
            if (na == 4) req_a = 1'b0;
            if (nb == 4) req_b = 1'b0;
        end
        chk("tie_acks_a", na, 4);
        chk("tie_acks_b", nb, 4);
        chk("tie_all_served", sb.size(), 0);
        sb.delete();

        for (int i = 0; i < 8; i++) do_access(vecs[i]);
        chk("wr_word_lo", 32'(mem[16'hFFFF]), 32'h0000_00EF);
        chk("wr_word_hi_wrap", 32'(mem[16'h0000]), 32'h0000_00BE);
        chk("wr_byte", 32'(mem[16'h0100]), 32'h0000_0077);
        chk("wr_byte_only", 32'(mem[16'h0101]), 0);

        // Reset during HI of a word write: no ack, low byte stays written.
        wait_idle();
        drive(1'b1, 1'b1, 1'b1, 2'b00, 16'h0200, 16'hC3A5);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        chk("abort_in_hi", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0201, 8'hC3});
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {mem_en, mem_we, ack_a, ack_b, busy, mem_addr, mem_wdata}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_lo_kept", 32'(mem[16'h0200]), 32'h0000_00A5);
        chk("abort_hi_unwritten", 32'(mem[16'h0201]), 0);
        do_access(vecs[0]);
        do_access(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width of both request ports and the memory port.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports, per requester x in {a,b}: req_x  input  1  access request; we_x  input  1  1=write, 0=read; size_x  input  2  00=word, 01=byte zero-extend, 10=byte sign-extend, 11=as 01.
REQ-004 SHALL have ports, per requester x: addr_x  input  ADDR_W  byte address; wdata_x  input  16  write data, low byte at addr; ack_x  output  1  one-cycle completion pulse; rdata_x  output  16  read result.
REQ-005 SHALL have ports: mem_en  output  1  memory strobe; mem_we  output  1  write strobe; mem_addr  output  ADDR_W  byte address; mem_wdata  output  8  write byte; mem_rdata  input  8  read byte, valid one cycle after a read strobe.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, LO, HI, FIN.
REQ-008 In IDLE, when any req_x is high, SHALL grant one port, latch its we/size/addr/wdata, and go to LO at the next edge.
REQ-009 Ties SHALL be resolved round-robin: grant the port not granted most recently; a lone requester SHALL always be granted.
REQ-010 LO: mem_en=1, mem_addr=latched addr, mem_we=latched we, mem_wdata=wdata[7:0]; next state HI for word, FIN for byte.
REQ-011 HI: mem_en=1, mem_addr=addr+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000), mem_we=latched we, mem_wdata=wdata[15:8]; for reads, mem_rdata is latched as low byte at the end of HI; next state FIN.
REQ-012 FIN: mem_en=0; ack of granted port=1 for exactly this cycle; next state IDLE.
REQ-013 Read result in FIN: word = {mem_rdata, latched low byte}; size 01/11 = {8'h00, mem_rdata}; size 10 = {8{mem_rdata[7]}, mem_rdata}.
REQ-014 rdata_x SHALL equal the read result only while ack_x=1 for a read; otherwise 16'h0000.
REQ-015 Latency from granting edge to ack: word 3 cycles, byte 2 cycles; writes identical to reads.
REQ-016 Outside LO and HI, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-017 Requester inputs SHALL be ignored outside IDLE; changes after grant do not affect the access in flight.
REQ-018 Requester SHALL drop req_x in the cycle after ack_x; req_x high in IDLE is always treated as a new request.
REQ-019 The non-granted port's request SHALL remain pending and be granted in the IDLE immediately following FIN.
REQ-020 ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, clear latched request and low-byte registers, and drive all outputs to 0, including mid-access.
REQ-022 Reset SHALL set round-robin history to "b granted last" so port a wins the first tie.
REQ-023 An access aborted by reset SHALL never produce ack; a partially written word is not rolled back.

Configuration
REQ-024 Macro MEM_ARB_FIXED_PRIO_EN: when defined, port a SHALL win every tie and round-robin history SHALL not be implemented; when undefined, REQ-009 applies.

Verification
REQ-025 Word read a, addr 0x0010, mem holds 0x34@0x10 and 0x12@0x11 -> strobes 0x0010 then 0x0011, ack_a 3 cycles after grant, rdata_a=0x1234.
REQ-026 Byte reads at addr 0x0003 holding 0x85: size 01 -> rdata=0x0085, size 10 -> rdata=0xFF85, ack 2 cycles after grant.
REQ-027 Word write b, addr 0xFFFF, wdata 0xBEEF -> mem writes 0xEF@0xFFFF then 0xBE@0x0000, ack_b once, rdata_b=0.
REQ-028 req_a and req_b high together for four accesses each -> grants alternate a,b,a,b (with MEM_ARB_FIXED_PRIO_EN: all a first, then b).
REQ-029 rst_n asserted during HI of a word write -> mem_en low immediately, no ack, busy=0, next request served normally after release.
